// File: rtl/myo_sched_pkg.sv
// rtl/myo_sched_pkg.sv - FSM state codes, timing defaults and index-width helper for the SPI scheduler
package myo_sched_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SELECT = 4'd1;
  localparam logic [3:0] ST_SETUP  = 4'd2;
  localparam logic [3:0] ST_FETCH  = 4'd3;
  localparam logic [3:0] ST_START  = 4'd4;
  localparam logic [3:0] ST_WAIT   = 4'd5;
  localparam logic [3:0] ST_STORE  = 4'd6;
  localparam logic [3:0] ST_GAP    = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;

  localparam int SETUP_CYCLES_DEF   = 4;
  localparam int GAP_CYCLES_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/myo_tick_gen.sv
// rtl/myo_tick_gen.sv - periodic update tick; counter held at zero while run is low
module myo_tick_gen #(
  parameter int PERIOD = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || cnt_q == 32'(PERIOD - 1)) cnt_d = '0;
    else cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == 32'(PERIOD - 1));

endmodule

// File: rtl/myo_spi_scheduler.sv
// rtl/myo_spi_scheduler.sv - walks enabled motor boards in index order, one SPI frame each per update cycle
module myo_spi_scheduler
  import myo_sched_pkg::*;
#(
  parameter int NUMBER_OF_MOTORS = 9,
  parameter int FRAME_WORDS      = 4,
  parameter int CLOCK_FREQ_HZ    = 50000000,
  parameter int UPDATE_FREQ_HZ   = 100,
  parameter int SETUP_CYCLES     = SETUP_CYCLES_DEF,
  parameter int GAP_CYCLES       = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES   = TIMEOUT_CYCLES_DEF,
  localparam int MW = idx_width(NUMBER_OF_MOTORS),
  localparam int WW = idx_width(FRAME_WORDS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        periodic,
  input  logic                        sw_trigger,
  input  logic [NUMBER_OF_MOTORS-1:0] enable_mask,
  input  logic                        power_sense_n,
  output logic [NUMBER_OF_MOTORS-1:0] ss_n,
  output logic                        spi_start,
  output logic [15:0]                 spi_tx_data,
  input  logic                        spi_done,
  input  logic [15:0]                 spi_rx_data,
  output logic [MW-1:0]               tx_rd_motor,
  output logic [WW-1:0]               tx_rd_word,
  input  logic [15:0]                 tx_rd_data,
  output logic                        rx_we,
  output logic [MW-1:0]               rx_motor,
  output logic [WW-1:0]               rx_word,
  output logic [15:0]                 rx_data,
  output logic                        busy,
  output logic                        cycle_done,
  output logic [NUMBER_OF_MOTORS-1:0] timeout_mask,
  output logic [15:0]                 overrun_count
);

  // motor counter must be able to hold NUMBER_OF_MOTORS itself (the end marker)
  localparam int MW1 = idx_width(NUMBER_OF_MOTORS + 1);
  localparam logic [NUMBER_OF_MOTORS-1:0] SS_ONE = {{(NUMBER_OF_MOTORS-1){1'b0}}, 1'b1};

  logic                        tick, trigger, frame_active;
  logic [3:0]                  state_q, state_d;
  logic [MW1-1:0]              motor_q, motor_d;
  logic [MW-1:0]               mot_idx;
  logic [WW-1:0]               word_q, word_d;
  logic [15:0]                 cnt_q, cnt_d, rx_q, rx_d, ovr_q, ovr_d;
  logic [NUMBER_OF_MOTORS-1:0] mask_q, mask_d, tmo_q, tmo_d;
  logic                        busy_q, busy_d, abort_q, abort_d;

  myo_tick_gen #(.PERIOD(CLOCK_FREQ_HZ / UPDATE_FREQ_HZ)) u_tick (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  assign trigger = periodic ? tick : sw_trigger;
  assign mot_idx = motor_q[MW-1:0];

  always_comb begin
    state_d = state_q;
    motor_d = motor_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    abort_d = abort_q;
    ovr_d   = ovr_q;
    if (trigger && busy_q && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
    case (state_q)
      ST_IDLE: if (trigger && run && !power_sense_n) begin
        mask_d  = enable_mask;
        tmo_d   = '0;
        busy_d  = 1'b1;
        abort_d = 1'b0;
        motor_d = '0;
        state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (motor_q == MW1'(NUMBER_OF_MOTORS) || !run) state_d = ST_DONE;
        else if (!mask_q[mot_idx]) motor_d = motor_q + 1'b1;
        else begin
          word_d  = '0;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 16'(SETUP_CYCLES - 1)) state_d = ST_FETCH;
        else cnt_d = cnt_q + 16'd1;
      end
      ST_FETCH: state_d = ST_START;
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_done) begin
          rx_d    = spi_rx_data;
          state_d = ST_STORE;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          tmo_d[mot_idx] = 1'b1;
          cnt_d          = '0;
          state_d        = ST_GAP;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_STORE: begin
        if (word_q == WW'(FRAME_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          word_d  = word_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          motor_d = motor_q + 1'b1;
          state_d = (abort_q || power_sense_n || !run) ? ST_DONE : ST_SELECT;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // power loss abandons the frame; the gap still runs so the slave sees a clean deselect
    if (power_sense_n && state_q != ST_IDLE && state_q != ST_DONE) begin
      abort_d = 1'b1;
      if (state_q != ST_GAP) begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      motor_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      tmo_q   <= '0;
      rx_q    <= '0;
      ovr_q   <= '0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      motor_q <= motor_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      rx_q    <= rx_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
    end
  end

  assign frame_active = (state_q == ST_SETUP || state_q == ST_FETCH || state_q == ST_START ||
                         state_q == ST_WAIT  || state_q == ST_STORE) && !power_sense_n;

  assign ss_n          = frame_active ? ~(SS_ONE << mot_idx) : '1;
  assign spi_start     = (state_q == ST_START) && !power_sense_n;
  assign spi_tx_data   = spi_start ? tx_rd_data : 16'd0;
  assign tx_rd_motor   = mot_idx;
  assign tx_rd_word    = word_q;
  assign rx_we         = (state_q == ST_STORE) && !power_sense_n;
  assign rx_motor      = mot_idx;
  assign rx_word       = word_q;
  assign rx_data       = rx_q;
  assign busy          = busy_q;
  assign cycle_done    = (state_q == ST_DONE);
  assign timeout_mask  = tmo_q;
  assign overrun_count = ovr_q;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// tb/tb_myo_spi_scheduler.sv - directed vector bench for myo_spi_scheduler with SPI slave and register-file models
module tb_myo_spi_scheduler;

  localparam int NM = 9;
  localparam int GAP = 16;

  logic clock = 1'b0;
  logic reset, run, periodic, sw_trigger, power_sense_n;
  logic [8:0]  enable_mask, ss_n, timeout_mask;
  logic        spi_start, rx_we, busy, cycle_done;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rx_data = 16'd0;
  logic [15:0] tx_rd_data = 16'd0;
  logic [15:0] spi_tx_data, rx_data, overrun_count;
  logic [3:0]  tx_rd_motor, rx_motor;
  logic [1:0]  tx_rd_word, rx_word;

  always #5 clock = ~clock;

  myo_spi_scheduler #(.CLOCK_FREQ_HZ(4000), .UPDATE_FREQ_HZ(1)) dut (
    .clock(clock), .reset(reset), .run(run), .periodic(periodic), .sw_trigger(sw_trigger),
    .enable_mask(enable_mask), .power_sense_n(power_sense_n), .ss_n(ss_n),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_done(spi_done),
    .spi_rx_data(spi_rx_data), .tx_rd_motor(tx_rd_motor), .tx_rd_word(tx_rd_word),
    .tx_rd_data(tx_rd_data), .rx_we(rx_we), .rx_motor(rx_motor), .rx_word(rx_word),
    .rx_data(rx_data), .busy(busy), .cycle_done(cycle_done),
    .timeout_mask(timeout_mask), .overrun_count(overrun_count)
  );

  int total = 0;
  int bad = 0;
  int n_rx, n_start, n_done, multi, wc, cd, sp_m, sp_w;
  int silent = -1;
  int falls[NM];
  logic [8:0]  seen, prev_ss;
  logic [21:0] expq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // SPI slave answers 40 cycles after start; register file returns 0x5000+motor*16+word
  always @(negedge clock) begin : mon
    int m;
    int nlow;
    logic [21:0] e;
    nlow = $countones(~ss_n);
    m = -1;
    for (int i = 0; i < NM; i++) if (!ss_n[i]) m = i;
    if (spi_done) spi_done = 1'b0;
    if (ss_n == 9'h1FF) wc = 0;
    if (nlow > 1) multi++;
    for (int i = 0; i < NM; i++) if (prev_ss[i] && !ss_n[i]) falls[i]++;
    seen = seen | ~ss_n;
    prev_ss = ss_n;
    if (cycle_done) n_done++;
    if (rx_we) begin
      n_rx++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rx_write", {rx_motor, rx_word, rx_data}, e);
      end
    end
    if (spi_start) begin
      n_start++;
      chk("start_one_ss_low", nlow, 1);
      if (m >= 0) chk("spi_tx_data", spi_tx_data, 16'(16'h5000 + m * 16 + wc));
      if (m >= 0 && m != silent) begin
        cd = 40; sp_m = m; sp_w = wc;
      end
      wc++;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        spi_done = 1'b1;
        spi_rx_data = 16'(16'hA500 + sp_m * 4 + sp_w);
      end
    end
    tx_rd_data = 16'(16'h5000 + tx_rd_motor * 16 + tx_rd_word);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_mon();
    n_rx = 0; n_start = 0; n_done = 0; multi = 0; wc = 0;
    seen = '0; prev_ss = '1;
    for (int i = 0; i < NM; i++) falls[i] = 0;
    expq.delete();
  endtask

  task automatic do_reset();
    run = 0; periodic = 0; sw_trigger = 0; power_sense_n = 0; enable_mask = '0;
    reset = 1;
    step(50);
    reset = 0;
    step(1);
  endtask

  task automatic pulse_sw();
    sw_trigger = 1; step(1); sw_trigger = 0;
  endtask

  task automatic push_frames(input logic [8:0] mask, input int skip_m, input int ncyc);
    for (int c = 0; c < ncyc; c++)
      for (int m = 0; m < NM; m++)
        if (mask[m] && m != skip_m)
          for (int w = 0; w < 4; w++)
            expq.push_back({4'(m), 2'(w), 16'(16'hA500 + m * 4 + w)});
  endtask

  typedef struct {
    bit         per;
    logic [8:0] mask;
    int         silent;
    int         cyc;
    int         ncyc;
    int         exp_rx;
    logic [8:0] tmo;
  } vec_t;

  vec_t vec[5];

  initial begin
    int got, ferr;
    vec[0] = '{1'b1, 9'h1FF, -1, 10000, 2, 72, 9'h000};
    vec[1] = '{1'b0, 9'h005, -1, 800,   1, 8,  9'h000};
    vec[2] = '{1'b0, 9'h1FF, 3,  3000,  1, 32, 9'h008};
    vec[3] = '{1'b0, 9'h000, -1, 100,   1, 0,  9'h000};
    vec[4] = '{1'b0, 9'h100, -1, 600,   1, 4,  9'h000};

    run = 0; periodic = 0; sw_trigger = 0; power_sense_n = 0; enable_mask = '0;
    reset = 1;
    step(3);
    chk("reset_ss_n", ss_n, 9'h1FF);
    chk("reset_ctl", {busy, cycle_done, spi_start, rx_we, timeout_mask, overrun_count}, 0);
    chk("reset_data", {spi_tx_data, rx_data, tx_rd_motor, tx_rd_word, rx_motor, rx_word}, 0);

    for (int r = 0; r < 5; r++) begin
      do_reset();
      clear_mon();
      silent = vec[r].silent;
      push_frames(vec[r].mask, vec[r].silent, vec[r].ncyc);
      enable_mask = vec[r].mask;
      periodic = vec[r].per;
      run = 1;
      if (!vec[r].per) pulse_sw();
      step(vec[r].cyc);
      chk($sformatf("v%0d_rx_count", r), n_rx, vec[r].exp_rx);
      chk($sformatf("v%0d_cycle_done", r), n_done, vec[r].ncyc);
      chk($sformatf("v%0d_ss_seen", r), seen, vec[r].mask);
      chk($sformatf("v%0d_timeout", r), timeout_mask, vec[r].tmo);
      chk($sformatf("v%0d_overrun", r), overrun_count, 0);
      chk($sformatf("v%0d_one_low", r), multi, 0);
      chk($sformatf("v%0d_idle", r), busy, 0);
      ferr = 0;
      for (int i = 0; i < NM; i++)
        if (falls[i] != (vec[r].mask[i] ? vec[r].ncyc : 0)) ferr++;
      chk($sformatf("v%0d_ss_windows", r), ferr, 0);
      run = 0;
    end
    silent = -1;

    // two software triggers 10 cycles apart, then a trigger during cycle_done
    do_reset(); clear_mon();
    enable_mask = 9'h001; run = 1;
    push_frames(9'h001, -1, 2);
    pulse_sw(); step(9); pulse_sw();
    for (int i = 0; i < 400 && n_done < 1; i++) step(1);
    chk("ovr_single", overrun_count, 1);
    chk("ovr_done", n_done, 1);
    pulse_sw();
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin step(1); if (cycle_done) got = 1; end
    chk("ovr_reach_done", got, 1);
    sw_trigger = 1; step(1); sw_trigger = 0;
    step(20);
    chk("ovr_same_cycle", overrun_count, 2);
    chk("ovr_no_restart", busy, 0);
    chk("ovr_rx", n_rx, 8);

    // run dropped during motor 0 finishes that frame only
    do_reset(); clear_mon();
    enable_mask = 9'h1FF; run = 1;
    push_frames(9'h001, -1, 1);
    pulse_sw();
    for (int i = 0; i < 100 && n_start < 1; i++) step(1);
    run = 0;
    for (int i = 0; i < 400 && n_done < 1; i++) step(1);
    chk("stop_done", n_done, 1);
    chk("stop_rx", n_rx, 4);
    chk("stop_seen", seen, 9'h001);
    chk("stop_idle", busy, 0);

    // power loss during motor 1 word 2
    do_reset(); clear_mon();
    enable_mask = 9'h1FF; run = 1;
    push_frames(9'h001, -1, 1);
    push_frames(9'h002, -1, 1);
    void'(expq.pop_back()); void'(expq.pop_back());
    pulse_sw();
    for (int i = 0; i < 800 && n_start < 7; i++) step(1);
    chk("pwr_reach_word2", n_start, 7);
    step(5);
    power_sense_n = 1;
    step(1);
    chk("pwr_ss_high", ss_n, 9'h1FF);
    got = 0;
    for (int i = 1; i < GAP + 2 && !got; i++) begin step(1); if (cycle_done) got = 1; end
    chk("pwr_done_in_time", got, 1);
    step(50);
    chk("pwr_no_start", n_start, 7);
    chk("pwr_rx", n_rx, 6);
    chk("pwr_idle", busy, 0);
    power_sense_n = 0;

    // reset while waiting on spi_done; the late done must not write
    do_reset(); clear_mon();
    enable_mask = 9'h001; run = 1;
    pulse_sw();
    for (int i = 0; i < 100 && n_start < 1; i++) step(1);
    step(5);
    reset = 1;
    step(1);
    chk("rst_ss_high", ss_n, 9'h1FF);
    chk("rst_busy", {busy, spi_start}, 0);
    reset = 0;
    step(60);
    chk("rst_late_done", n_rx, 0);
    chk("rst_no_start", n_start, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
